// File: rtl/conv_linebuf_ctrl.sv
// rtl/conv_linebuf_ctrl.sv - KxK sliding-window line buffer controller
//
// Optional feature macro: CONV_STALL_EN (window back-pressure from out_ready).
//
// Ports:
//   clk, rst               clock (rising edge), synchronous active-low reset
//   start                  latch stride/row_len/num_rows and begin a frame (IDLE only)
//   stride, row_len,       per-frame configuration, sampled only on an accepted start
//   num_rows
//   in_valid / in_ready    raster pixel handshake
//   out_ready              MAC array ready for a window (stall build only)
//   ff_rst                 line-buffer FIFO reset (held whenever no frame is running)
//   ff_wen / ff_ren        per-stage FIFO write / read enables (combinational)
//   win_valid              registered flag: last accepted pixel completed an aligned window
//   col_cnt / row_cnt      position of the last accepted pixel
//   busy                   frame in progress
//   done                   one-cycle pulse after the last pixel is accepted
//   cfg_err                one-cycle pulse after a start with an illegal configuration
module conv_linebuf_ctrl #(
    parameter int KERNEL   = 3,
    parameter int DIM_W    = 5,
    parameter int STRIDE_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [STRIDE_W-1:0] stride,
    input  logic [DIM_W-1:0]    row_len,
    input  logic [DIM_W-1:0]    num_rows,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                out_ready,
    output logic                ff_rst,
    output logic [KERNEL-2:0]   ff_wen,
    output logic [KERNEL-2:0]   ff_ren,
    output logic                win_valid,
    output logic [DIM_W-1:0]    col_cnt,
    output logic [DIM_W-1:0]    row_cnt,
    output logic                busy,
    output logic                done,
    output logic                cfg_err
);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN} state_t;

    state_t state, state_nxt;

    logic [STRIDE_W-1:0] stride_q;
    logic [DIM_W-1:0]    len_q;
    logic [DIM_W-1:0]    rows_q;

    // Position of the next pixel to be accepted, and its stride phases.
    logic [DIM_W-1:0]    col_pos;
    logic [DIM_W-1:0]    row_pos;
    logic [STRIDE_W-1:0] col_ph;
    logic [STRIDE_W-1:0] row_ph;

    logic cfg_bad;
    logic accept;
    logic at_col_end;
    logic at_last;
    logic win_hit;
    logic win_hold;

    assign cfg_bad = (stride == '0) || (32'(stride) > 32'd4) ||
                     (32'(row_len) < KERNEL) || (32'(num_rows) < KERNEL);

`ifdef CONV_STALL_EN
    // An unconsumed window freezes the pixel stream until the MAC array takes it.
    assign win_hold = win_valid & ~out_ready;
`else
    // out_ready has no effect without stall support.
    assign win_hold = out_ready & 1'b0;
`endif

    assign in_ready   = (state == RUN) && !win_hold;
    assign accept     = in_valid & in_ready;
    assign at_col_end = (col_pos == len_q - DIM_W'(1));
    assign at_last    = at_col_end && (row_pos == rows_q - DIM_W'(1));
    assign win_hit    = (32'(row_pos) >= KERNEL - 1) && (32'(col_pos) >= KERNEL - 1) &&
                        (col_ph == '0) && (row_ph == '0);

    // Stage i carries row i, so it starts writing once row i arrives and
    // starts reading (forwarding to stage i+1) once row i+1 arrives.
    always_comb begin
        ff_wen = '0;
        ff_ren = '0;
        for (int i = 0; i < KERNEL - 1; i++) begin
            ff_wen[i] = accept && (32'(row_pos) >= i);
            ff_ren[i] = accept && (32'(row_pos) >= i + 1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        ff_rst    = 1'b0;
        case (state)
            IDLE: begin
                ff_rst = 1'b1;
                if (start && !cfg_bad) begin
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                ff_rst    = 1'b1;
                busy      = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (accept && at_last) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stride_q  <= '0;
            len_q     <= '0;
            rows_q    <= '0;
            col_pos   <= '0;
            row_pos   <= '0;
            col_ph    <= '0;
            row_ph    <= '0;
            col_cnt   <= '0;
            row_cnt   <= '0;
            win_valid <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            done    <= 1'b0;
            cfg_err <= 1'b0;

            if (state == IDLE && start) begin
                if (cfg_bad) begin
                    cfg_err <= 1'b1;
                end else begin
                    stride_q <= stride;
                    len_q    <= row_len;
                    rows_q   <= num_rows;
                end
            end

            if (state == CLEAR) begin
                col_pos <= '0;
                row_pos <= '0;
                col_ph  <= '0;
                row_ph  <= '0;
                col_cnt <= '0;
                row_cnt <= '0;
            end

            if (accept) begin
                win_valid <= win_hit;
            end else if (!win_hold) begin
                win_valid <= 1'b0;
            end

            if (accept) begin
                col_cnt <= col_pos;
                row_cnt <= row_pos;
                done    <= at_last;
                // Phases are forced to 0 until the first full window edge, so
                // they read 0 at col/row K-1 and then count modulo stride.
                if (at_col_end) begin
                    col_pos <= '0;
                    col_ph  <= '0;
                    row_pos <= row_pos + DIM_W'(1);
                    if (32'(row_pos) < KERNEL - 1 || row_ph == stride_q - STRIDE_W'(1)) begin
                        row_ph <= '0;
                    end else begin
                        row_ph <= row_ph + STRIDE_W'(1);
                    end
                end else begin
                    col_pos <= col_pos + DIM_W'(1);
                    if (32'(col_pos) < KERNEL - 1 || col_ph == stride_q - STRIDE_W'(1)) begin
                        col_ph <= '0;
                    end else begin
                        col_ph <= col_ph + STRIDE_W'(1);
                    end
                end
            end
        end
    end

endmodule
